freq_sweep_ctl: RTL and testbench



---
 rtl/freq_sweep_ctl.sv | 164 ++++++++++++++++
 tb/tb_freq_sweep_ctl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_ctl.sv
// Frequency sweep sequencer feeding the freq_ctl code of freq_ctl_data.
// Optional build macro SWEEP_TRIANGLE_EN: continuous sweeps ping-pong instead of sawtooth wrap.
module freq_sweep_ctl #(
  parameter int unsigned FREQ_W  = 12,
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FREQ_W-1:0]  freq_ctl,
  output logic               freq_valid,
  output logic               busy,
  output logic               done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state,    w_state_nxt;
  logic [FREQ_W-1:0]    r_freq,     w_freq_nxt;
  logic                 r_valid,    w_valid_nxt;
  logic                 r_busy,     w_busy_nxt;
  logic                 r_done,     w_done_nxt;
  logic [DWELL_W-1:0]   r_cnt,      w_cnt_nxt;
  logic [FREQ_W-1:0]    r_fa,       w_fa_nxt;
  logic [FREQ_W-1:0]    r_fb,       w_fb_nxt;
  logic [FREQ_W-1:0]    r_step,     w_step_nxt;
  logic [DWELL_W-1:0]   r_dwell_m1, w_dwell_m1_nxt;
  logic                 r_mode,     w_mode_nxt;
  logic                 r_tgt_b,    w_tgt_b_nxt;

  logic [DWELL_W-1:0]   w_d_m1;
  logic [FREQ_W-1:0]    w_tgt;
  logic                 w_up;

  // One step from cur toward tgt, clamped to tgt on reaching/passing it or on wrap.
  function automatic logic [FREQ_W-1:0] f_next(input logic [FREQ_W-1:0] cur,
                                               input logic [FREQ_W-1:0] tgt,
                                               input logic [FREQ_W-1:0] step,
                                               input logic              up);
    logic [FREQ_W:0] s;
    if (up) begin
      s = {1'b0, cur} + {1'b0, step};
      f_next = (s[FREQ_W] || (s[FREQ_W-1:0] >= tgt)) ? tgt : s[FREQ_W-1:0];
    end else begin
      s = {1'b0, cur} - {1'b0, step};
      f_next = (s[FREQ_W] || (s[FREQ_W-1:0] <= tgt)) ? tgt : s[FREQ_W-1:0];
    end
  endfunction

  assign w_d_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  assign w_tgt  = r_tgt_b ? r_fb : r_fa;
  assign w_up   = r_tgt_b ? (r_fa <= r_fb) : (r_fb <= r_fa);

`ifdef SWEEP_TRIANGLE_EN
  logic [FREQ_W-1:0]    w_other;
  assign w_other = r_tgt_b ? r_fa : r_fb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_fa       <= '0;
      r_fb       <= '0;
      r_step     <= '0;
      r_dwell_m1 <= '0;
      r_mode     <= 1'b0;
      r_tgt_b    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_freq     <= w_freq_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fa       <= w_fa_nxt;
      r_fb       <= w_fb_nxt;
      r_step     <= w_step_nxt;
      r_dwell_m1 <= w_dwell_m1_nxt;
      r_mode     <= w_mode_nxt;
      r_tgt_b    <= w_tgt_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_freq_nxt     = r_freq;
    w_valid_nxt    = 1'b0;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_fa_nxt       = r_fa;
    w_fb_nxt       = r_fb;
    w_step_nxt     = r_step;
    w_dwell_m1_nxt = r_dwell_m1;
    w_mode_nxt     = r_mode;
    w_tgt_b_nxt    = r_tgt_b;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          // A zero step collapses the sweep onto the start code.
          w_fa_nxt       = f_start;
          w_fb_nxt       = (f_step == '0) ? f_start : f_stop;
          w_step_nxt     = f_step;
          w_dwell_m1_nxt = w_d_m1;
          w_mode_nxt     = mode;
          w_tgt_b_nxt    = 1'b1;
          w_freq_nxt     = f_start;
          w_valid_nxt    = 1'b1;
          w_busy_nxt     = 1'b1;
          w_cnt_nxt      = w_d_m1;
          w_state_nxt    = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else if (r_freq != w_tgt) begin
          w_freq_nxt  = f_next(r_freq, w_tgt, r_step, w_up);
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_dwell_m1;
        end else if (!r_mode) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = r_dwell_m1;
`ifdef SWEEP_TRIANGLE_EN
          if (r_fa == r_fb) begin
            w_freq_nxt = r_fa;
          end else begin
            w_tgt_b_nxt = !r_tgt_b;
            w_freq_nxt  = f_next(r_freq, w_other, r_step, !w_up);
          end
`else
          w_freq_nxt = r_fa;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign freq_ctl   = r_freq;
  assign freq_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_freq_sweep_ctl.sv
// Self-checking bench for freq_sweep_ctl: table vectors, hand-written corner sequences, random sweeps vs. a list model.
module tb_freq_sweep_ctl;
  localparam int unsigned FREQ_W  = 12;
  localparam int unsigned DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, mode;
  logic [FREQ_W-1:0]  f_start, f_stop, f_step;
  logic [DWELL_W-1:0] dwell;
  logic [FREQ_W-1:0]  freq_ctl;
  logic               freq_valid, busy, done;

  int total = 0;
  int bad   = 0;
  int exp_seq[$];

  typedef struct {
    int fa, fb, st, dw, md, n;
    int codes[8];
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  freq_sweep_ctl #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .freq_ctl(freq_ctl), .freq_valid(freq_valid), .busy(busy), .done(done)
  );

  task automatic check(input string name, input int ef, input bit ev, input bit eb, input bit ed);
    total++;
    if (freq_ctl !== FREQ_W'(ef) || freq_valid !== ev || busy !== eb || done !== ed) begin
      bad++;
      $display("FAIL %s t=%0t: got freq_ctl=%0d valid=%0b busy=%0b done=%0b, expected freq_ctl=%0d valid=%0b busy=%0b done=%0b",
               name, $time, freq_ctl, freq_valid, busy, done, ef, ev, eb, ed);
    end
  endtask

  function automatic int step_to(input int c, input int to, input int st);
    if (to > c) return (c + st >= to) ? to : c + st;
    return (c - st <= to) ? to : c - st;
  endfunction

  // Expected code list: single-shot gives the whole sweep, continuous gives n codes of the repeating pattern.
  task automatic model(input int fa, input int fb, input int st, input int md, input int n);
    int fwd[$];
    int per[$];
    int c;
    exp_seq = {};
    fwd.push_back(fa);
    c = fa;
    if (st != 0)
      while (c != fb) begin
        c = step_to(c, fb, st);
        fwd.push_back(c);
      end
    if (md == 0) begin
      exp_seq = fwd;
    end else begin
      per = fwd;
`ifdef SWEEP_TRIANGLE_EN
      if (fwd.size() > 1) begin
        c = fb;
        while (c != fa) begin
          c = step_to(c, fa, st);
          if (c != fa) per.push_back(c);
        end
      end
`endif
      for (int i = 0; i < n; i++) exp_seq.push_back(per[i % per.size()]);
    end
  endtask

  // Runs one sweep from IDLE and compares every cycle against exp_seq[0..n-1].
  task automatic run(input string name, input int fa, input int fb, input int st,
                     input int dw, input int md, input int n);
    int d;
    int last;
    d = (dw == 0) ? 1 : dw;
    @(negedge clk);
    f_start = FREQ_W'(fa);
    f_stop  = FREQ_W'(fb);
    f_step  = FREQ_W'(st);
    dwell   = DWELL_W'(dw);
    mode    = md[0];
    start   = 1'b1;
    stop    = 1'b0;
    for (int k = 0; k < n * d; k++) begin
      @(negedge clk);
      start   = (k < n * d - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      f_start = FREQ_W'($urandom);
      f_stop  = FREQ_W'($urandom);
      f_step  = FREQ_W'($urandom);
      dwell   = DWELL_W'($urandom_range(0, 9));
      mode    = 1'($urandom);
      check(name, exp_seq[k / d], (k % d) == 0, 1'b1, 1'b0);
    end
    last = exp_seq[n - 1];
    if (md == 0) begin
      @(negedge clk);
      check({name, "_done"}, last, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check({name, "_idle"}, last, 1'b0, 1'b0, 1'b0);
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check({name, "_stop"}, last, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int fa, fb, st, dw, md, span, n;

    vecs[0] = '{fa:100,  fb:130,  st:10, dw:4, md:0, n:4, codes:'{100, 110, 120, 130, 0, 0, 0, 0}};
    vecs[1] = '{fa:100,  fb:125,  st:10, dw:3, md:0, n:4, codes:'{100, 110, 120, 125, 0, 0, 0, 0}};
    vecs[2] = '{fa:4090, fb:4095, st:10, dw:2, md:0, n:2, codes:'{4090, 4095, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{fa:200,  fb:170,  st:15, dw:0, md:0, n:3, codes:'{200, 185, 170, 0, 0, 0, 0, 0}};
    vecs[4] = '{fa:50,   fb:50,   st:7,  dw:3, md:0, n:1, codes:'{50, 0, 0, 0, 0, 0, 0, 0}};
    vecs[5] = '{fa:60,   fb:90,   st:0,  dw:2, md:0, n:1, codes:'{60, 0, 0, 0, 0, 0, 0, 0}};
    vecs[6] = '{fa:5,    fb:0,    st:10, dw:1, md:0, n:2, codes:'{5, 0, 0, 0, 0, 0, 0, 0}};
`ifdef SWEEP_TRIANGLE_EN
    vecs[7] = '{fa:10,  fb:30,  st:10, dw:2, md:1, n:8, codes:'{10, 20, 30, 20, 10, 20, 30, 20}};
    vecs[8] = '{fa:100, fb:125, st:10, dw:1, md:1, n:8, codes:'{100, 110, 120, 125, 115, 105, 100, 110}};
`else
    vecs[7] = '{fa:10,  fb:30,  st:10, dw:2, md:1, n:8, codes:'{10, 20, 30, 10, 20, 30, 10, 20}};
    vecs[8] = '{fa:100, fb:125, st:10, dw:1, md:1, n:8, codes:'{100, 110, 120, 125, 100, 110, 120, 125}};
`endif

    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (3) @(negedge clk);
    check("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // start and stop together in IDLE must not launch a sweep
    @(negedge clk);
    f_start = 12'd77; f_stop = 12'd99; f_step = 12'd1; dwell = 24'd1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      exp_seq = {};
      for (int j = 0; j < vecs[i].n; j++) exp_seq.push_back(vecs[i].codes[j]);
      run($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st, vecs[i].dw, vecs[i].md, vecs[i].n);
    end

    // Stop in the second dwell of 0->1000 step 100, then restart and ignore start while busy.
    @(negedge clk);
    f_start = 12'd0; f_stop = 12'd1000; f_step = 12'd100; dwell = 24'd3; mode = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0; check("stop_c0", 0, 1'b1, 1'b1, 1'b0);
    @(negedge clk); check("stop_c1", 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); check("stop_c2", 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); check("stop_c3", 100, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; check("stop_hit", 100, 1'b0, 1'b0, 1'b0);
    @(negedge clk); check("stop_hold", 100, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; check("restart", 0, 1'b1, 1'b1, 1'b0);
    f_start = 12'd500; start = 1'b1;
    @(negedge clk); start = 1'b0; check("start_busy", 0, 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; check("stop_end", 0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      fa = int'($urandom_range(0, 4095));
      fb = (r % 5 == 0) ? ((r % 10 == 0) ? 4095 : 0) : int'($urandom_range(0, 4095));
      span = (fa > fb) ? fa - fb : fb - fa;
      st = ($urandom_range(0, 7) == 0) ? 0 : span / 6 + 1 + int'($urandom_range(0, 100));
      if (st > 4095) st = 4095;
      dw = int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 1));
      model(fa, fb, st, md, 10);
      n = (md != 0) ? 10 : exp_seq.size();
      run($sformatf("rnd%0d", r), fa, fb, st, dw, md, n);
    end

    // Asynchronous reset in the middle of a sweep.
    @(negedge clk);
    f_start = 12'd100; f_stop = 12'd130; f_step = 12'd10; dwell = 24'd4; mode = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst", 110, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", 0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
